// File: rtl/decode_stage.sv
// decode_stage: registered RISC-V decode stage with a DEPTH-entry FIFO.
// Each accepted instruction is decoded combinationally into register
// indices, function fields, an XLEN-wide immediate and an illegal flag.
// The decoded entry is written into the FIFO tail. The head entry drives
// the outputs.
// Configuration macro: DECODE_M_EXT_EN. When it is defined, the OP opcode
// with funct7 = 0000001 (MUL/DIV) decodes as legal.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [XLEN-1:0]              in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [6:0]                   out_opcode,
    output logic [4:0]                   out_rd,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [2:0]                   out_funct3,
    output logic [6:0]                   out_funct7,
    output logic [XLEN-1:0]              out_imm,
    output logic [XLEN-1:0]              out_pc,
    output logic                         out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   out_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Supported major opcodes
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [6:0]      dec_opcode;
    logic [6:0]      dec_funct7;
    logic [31:0]     dec_imm32_raw;   // immediate already sign-extended to 32 bits
    logic [31:0]     dec_imm32;       // immediate after illegal forcing
    logic [XLEN-1:0] dec_imm;
    logic            dec_opcode_known;
    logic            dec_funct7_ok;
    logic            dec_illegal;
    entry_t          dec_entry;

    assign dec_opcode = in_instr[6:0];
    assign dec_funct7 = in_instr[31:25];

    // Select the immediate format from the opcode and flag unknown opcodes
    always_comb begin
        dec_imm32_raw    = '0;
        dec_opcode_known = 1'b0;
        case (dec_opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                dec_opcode_known = 1'b1;
                dec_imm32_raw    = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_STORE: begin
                dec_opcode_known = 1'b1;
                dec_imm32_raw    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OPC_BRANCH: begin
                dec_opcode_known = 1'b1;
                dec_imm32_raw    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                    in_instr[30:25], in_instr[11:8], 1'b0};
            end
            OPC_JAL: begin
                dec_opcode_known = 1'b1;
                dec_imm32_raw    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                    in_instr[20], in_instr[30:21], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_opcode_known = 1'b1;
                dec_imm32_raw    = {in_instr[31:12], 12'b0};
            end
            OPC_OP, OPC_SYSTEM, OPC_MISC_MEM: begin
                dec_opcode_known = 1'b1;
                dec_imm32_raw    = '0;
            end
            default: begin
                dec_opcode_known = 1'b0;
                dec_imm32_raw    = '0;
            end
        endcase
    end

    // Register-register ops accept only the base funct7 values (plus MUL/DIV when enabled)
    always_comb begin
`ifdef DECODE_M_EXT_EN
        dec_funct7_ok = (dec_funct7 == 7'b0000000) || (dec_funct7 == 7'b0100000) ||
                        (dec_funct7 == 7'b0000001);
`else
        dec_funct7_ok = (dec_funct7 == 7'b0000000) || (dec_funct7 == 7'b0100000);
`endif
    end

    assign dec_illegal = (in_instr[1:0] != 2'b11) || !dec_opcode_known ||
                         ((dec_opcode == OPC_OP) && !dec_funct7_ok);

    // An illegal entry still travels down the pipe but never carries an immediate
    assign dec_imm32 = dec_illegal ? 32'd0 : dec_imm32_raw;

    // Every 32-bit immediate format is sign-extended from instr[31], so
    // widening to XLEN only needs to replicate bit 31.
    generate
        if (XLEN > 32) begin : g_imm_wide
            assign dec_imm = {{(XLEN-32){dec_imm32[31]}}, dec_imm32};
        end else begin : g_imm_narrow
            assign dec_imm = dec_imm32;
        end
    endgenerate

    assign dec_entry.opcode  = dec_opcode;
    assign dec_entry.rd      = in_instr[11:7];
    assign dec_entry.rs1     = in_instr[19:15];
    assign dec_entry.rs2     = in_instr[24:20];
    assign dec_entry.funct3  = in_instr[14:12];
    assign dec_entry.funct7  = dec_funct7;
    assign dec_entry.imm     = dec_imm;
    assign dec_entry.pc      = in_pc;
    assign dec_entry.illegal = dec_illegal;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          push;
    logic          pop;
    logic          wr_en;

    // in_ready depends only on the occupancy, never on out_ready
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // A push coinciding with flush is accepted by the handshake but discarded
    assign wr_en     = push && !flush;

    // Next pointer and occupancy; flush overrides push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage: one register per slot so reset can clear it at once
    // ------------------------------------------------------------------
    entry_t mem_q [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture the decoded instruction when this slot is the tail
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q[gi] <= '0;
                end else if (wr_en && (wr_ptr_q == PW'(gi))) begin
                    mem_q[gi] <= dec_entry;
                end
            end
        end
    endgenerate

    // Head entry drives the outputs; the fields are stale when empty
    entry_t head;
    assign head = mem_q[rd_ptr_q];

    assign out_opcode  = head.opcode;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_funct3  = head.funct3;
    assign out_funct7  = head.funct7;
    assign out_imm     = head.imm;
    assign out_pc      = head.pc;
    assign out_illegal = head.illegal;
    assign out_count   = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed-vector bench for decode_stage.
// One XLEN=32 instance carries most vectors; an XLEN=64 instance checks
// the widened U-type immediate. Honours DECODE_M_EXT_EN for the MUL vector.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;

    // XLEN = 32 instance
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic        out_illegal;
    logic [1:0]  out_count;

    // XLEN = 64 instance
    logic        flush64;
    logic        in_valid64;
    logic        in_ready64;
    logic [31:0] in_instr64;
    logic [63:0] in_pc64;
    logic        out_valid64;
    logic        out_ready64;
    logic [6:0]  out_opcode64;
    logic [4:0]  out_rd64, out_rs1_64, out_rs2_64;
    logic [2:0]  out_funct3_64;
    logic [6:0]  out_funct7_64;
    logic [63:0] out_imm64;
    logic [63:0] out_pc64;
    logic        out_illegal64;
    logic [1:0]  out_count64;

    int vectors;
    int miscompares;

    decode_stage #(.XLEN(32), .DEPTH(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_pc(out_pc), .out_illegal(out_illegal), .out_count(out_count)
    );

    decode_stage #(.XLEN(64), .DEPTH(2)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(out_ready64),
        .out_opcode(out_opcode64), .out_rd(out_rd64), .out_rs1(out_rs1_64), .out_rs2(out_rs2_64),
        .out_funct3(out_funct3_64), .out_funct7(out_funct7_64), .out_imm(out_imm64),
        .out_pc(out_pc64), .out_illegal(out_illegal64), .out_count(out_count64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%0h", tag, observed);
        end
    endtask

    // Offer one instruction for a single edge; starts and ends at a negedge
    task automatic push32(input logic [31:0] instr, input logic [31:0] pc);
        in_instr = instr;
        in_pc    = pc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Pop the head entry with one ready edge; starts and ends at a negedge
    task automatic pop32();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic expect_mul_illegal;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_instr    = '0;
        in_pc       = '0;
        out_ready   = 1'b0;
        flush64     = 1'b0;
        in_valid64  = 1'b0;
        in_instr64  = '0;
        in_pc64     = '0;
        out_ready64 = 1'b0;
`ifdef DECODE_M_EXT_EN
        expect_mul_illegal = 1'b0;
`else
        expect_mul_illegal = 1'b1;
`endif

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count",     64'(out_count), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_imm",       64'(out_imm),   64'd0);
        check("rst_pc",        64'(out_pc),    64'd0);
        check("rst_opcode",    64'(out_opcode), 64'd0);
        check("rst_illegal",   64'(out_illegal), 64'd0);

        // addi x1,x0,-1
        push32(32'hFFF0_0093, 32'h0000_1000);
        check("addi_valid",   64'(out_valid),   64'd1);
        check("addi_rd",      64'(out_rd),      64'd1);
        check("addi_rs1",     64'(out_rs1),     64'd0);
        check("addi_funct3",  64'(out_funct3),  64'd0);
        check("addi_imm",     64'(out_imm),     64'hFFFF_FFFF);
        check("addi_illegal", 64'(out_illegal), 64'd0);
        check("addi_pc",      64'(out_pc),      64'h1000);
        check("addi_count",   64'(out_count),   64'd1);
        pop32();
        check("addi_popped_valid", 64'(out_valid), 64'd0);
        check("addi_popped_count", 64'(out_count), 64'd0);

        // beq x0,x0,-4
        push32(32'hFE00_0EE3, 32'h0000_1004);
        check("beq_imm",     64'(out_imm),    64'hFFFF_FFFC);
        check("beq_opcode",  64'(out_opcode), 64'h63);
        check("beq_illegal", 64'(out_illegal), 64'd0);
        pop32();

        // sw x2,-4(x1)
        push32(32'hFE20_AE23, 32'h0000_1008);
        check("sw_imm",    64'(out_imm),    64'hFFFF_FFFC);
        check("sw_rs2",    64'(out_rs2),    64'd2);
        check("sw_funct3", 64'(out_funct3), 64'd2);
        pop32();

        // jal ra,16
        push32(32'h0100_00EF, 32'h0000_100C);
        check("jal_imm", 64'(out_imm), 64'd16);
        check("jal_rd",  64'(out_rd),  64'd1);
        pop32();

        // sub x0,x1,x2 (legal R-type)
        push32(32'h4020_8033, 32'h0000_1010);
        check("sub_illegal", 64'(out_illegal), 64'd0);
        check("sub_funct7",  64'(out_funct7),  64'h20);
        check("sub_rs1",     64'(out_rs1),     64'd1);
        check("sub_imm",     64'(out_imm),     64'd0);
        pop32();

        // mul x3,x1,x2
        push32(32'h0220_81B3, 32'h0000_1014);
        check("mul_illegal", 64'(out_illegal), 64'(expect_mul_illegal));
        check("mul_rd",      64'(out_rd),      64'd3);
        pop32();

        // all-zero word
        push32(32'h0000_0000, 32'h0000_1018);
        check("zero_illegal", 64'(out_illegal), 64'd1);
        check("zero_pc",      64'(out_pc),      64'h1018);
        pop32();

        // unknown opcode with instr[31]=1: immediate forced to 0
        push32(32'hFFF0_007F, 32'h0000_101C);
        check("badop_illegal", 64'(out_illegal), 64'd1);
        check("badop_imm",     64'(out_imm),     64'd0);
        pop32();

        // XLEN=64: lui x5,0x80000
        in_instr64 = 32'h8000_02B7;
        in_pc64    = 64'h8000_0000_0000_2000;
        in_valid64 = 1'b1;
        @(negedge clk);
        in_valid64 = 1'b0;
        check("lui64_imm",   out_imm64,          64'hFFFF_FFFF_8000_0000);
        check("lui64_rd",    64'(out_rd64),      64'd5);
        check("lui64_pc",    out_pc64,           64'h8000_0000_0000_2000);
        check("lui64_valid", 64'(out_valid64),   64'd1);

        // Fill / drain with out_ready low, then high
        in_valid = 1'b1;
        in_instr = 32'h0010_0093; in_pc = 32'h100;
        @(negedge clk);
        check("fill1_count", 64'(out_count), 64'd1);
        check("fill1_ready", 64'(in_ready),  64'd1);
        in_instr = 32'h0020_0093; in_pc = 32'h104;
        @(negedge clk);
        check("fill2_count", 64'(out_count), 64'd2);
        check("fill2_ready", 64'(in_ready),  64'd0);
        in_instr = 32'h0030_0093; in_pc = 32'h108;
        @(negedge clk);
        check("fill3_held_count", 64'(out_count), 64'd2);
        check("fill3_head_pc",    64'(out_pc),    64'h100);
        out_ready = 1'b1;
        @(negedge clk);
        check("drain1_count", 64'(out_count), 64'd1);
        check("drain1_ready", 64'(in_ready),  64'd1);
        check("drain1_pc",    64'(out_pc),    64'h104);
        @(negedge clk);
        in_valid = 1'b0;
        check("drain2_count", 64'(out_count), 64'd1);
        check("drain2_pc",    64'(out_pc),    64'h108);
        check("drain2_rd",    64'(out_rd),    64'd1);
        check("drain2_imm",   64'(out_imm),   64'd3);
        @(negedge clk);
        out_ready = 1'b0;
        check("drain3_count", 64'(out_count), 64'd0);
        check("drain3_valid", 64'(out_valid), 64'd0);

        // Flush with count=2 and an instruction on offer
        push32(32'h0040_0093, 32'h200);
        push32(32'h0050_0093, 32'h204);
        check("preflush_count", 64'(out_count), 64'd2);
        in_valid = 1'b1;
        in_instr = 32'h0060_0093; in_pc = 32'h208;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", 64'(out_count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready),  64'd1);
        @(negedge clk);
        check("flush_dropped_count", 64'(out_count), 64'd0);

        // Asynchronous reset between edges with count=1
        push32(32'h0070_0093, 32'h300);
        check("prerst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_count", 64'(out_count), 64'd0);
        check("async_rst_pc",    64'(out_pc),    64'd0);
        check("async_rst_valid64", 64'(out_valid64), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push32(32'h0080_0093, 32'h400);
        check("post_rst_count", 64'(out_count), 64'd1);
        check("post_rst_pc",    64'(out_pc),    64'h400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
